lfsr_way_sel: RTL
=================

# lfsr_way_sel

Parametrised pseudo-random way selector for cache refill and arbitration victims. It is the successor of the fixed 8-bit LFSR picker and adds several capabilities:
- configurable LFSR width and way count, including non-power-of-two way counts;
- runtime reseeding;
- an availability mask with sequential probing past unavailable ways;
- a req/gnt handshake.

It sits between a cache controller's miss path and the tag/data refill logic.

## Interface
- `LfsrWidth`, default 16: LFSR state width; legal range 3..32.
- `NumWays`, default 8: selectable ways; 2 ≤ `NumWays` ≤ 2**`LfsrWidth`.
- `Seed`, default '0: reset and recovery value of the LFSR.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `seed_load_i`, in, 1: load `seed_i` into the LFSR this cycle.
- `seed_i`, in, `LfsrWidth`: seed value.
- `req_i`, in, 1: selection request; held high until `gnt_o`.
- `avail_i`, in, `NumWays`: 1 = way may be chosen; evaluated live each cycle.
- `gnt_o`, out, 1: one-cycle grant pulse; the outputs below are valid only while it is high.
- `way_oh_o`, out, `NumWays`: one-hot chosen way; all zero when `none_o`.
- `way_bin_o`, out, `$clog2(NumWays)`: binary chosen way.
- `none_o`, out, 1: no way available.

## Operation
- **LFSR:** Fibonacci XNOR. The next state is {q[W-2:0], ~(XOR of tap bits)}, with taps from the package table. Width 8 uses taps 8,6,5,4 (bits 7,5,4,3).
- **Candidate index:** `idx` = q[L-1:0], where L = `$clog2(NumWays)`. If `idx` ≥ `NumWays`, use `idx` − `NumWays`.
- **FSM states:** IDLE, PROBE, GRANT.
  - **IDLE**, with `req_i`:
    - `avail_i` == 0: register `none_o`=1 and go to GRANT.
    - `avail_i`[`idx`] set: register `idx` and go to GRANT.
    - otherwise: `cand_q` = `idx`+1 (wrapping to 0 at `NumWays`) and go to PROBE.
  - **PROBE:**
    - `req_i` low: abort to IDLE; no grant, LFSR unchanged.
    - `avail_i` == 0: go to GRANT with `none_o`.
    - `avail_i`[`cand_q`] set: register `cand_q` and go to GRANT.
    - otherwise: increment `cand_q` with wrap.
  - **GRANT:** `gnt_o`=1 and outputs driven from registers.
    - The LFSR advances one step only if the grant is not `none_o`.
    - Next state is IDLE, so back-to-back requests cost 2 cycles each minimum.
- **Seed load:** `seed_load_i` has priority over any advance in the same cycle. It does not disturb FSM state. An in-flight request completes using the already-captured candidate.
- **Reset:** LFSR = `Seed`, FSM = IDLE; `gnt_o`, `none_o`, `way_oh_o` and `way_bin_o` are all 0.

## Timing
- Grant latency after `req_i` rises in IDLE:
  - first candidate available: `gnt_o` in cycle +2 (IDLE → GRANT register);
  - k extra probes needed: +2+k;
  - worst case: +1+`NumWays`.
- All-zero `avail_i` when `req_i` is sampled in IDLE: grant with `none_o` in +2.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Async reset mid-PROBE or mid-GRANT returns to IDLE immediately. The grant is lost and the requester must reissue.

## Configuration
- `LFSR_WAY_SEL_LOCKUP_RECOVERY_EN`
  - **Defined:** a detector compares the LFSR state to all-ones, the XNOR lock-up state, reachable only through `seed_i`. On a match the LFSR is reloaded with `Seed` on the next clock edge, whatever the state of `seed_load_i`.
  - **Undefined:** no detector. The all-ones state persists, and every grant uses the same candidate.

## Structure
- Package `lfsr_way_sel_pkg`:
  - function `lfsr_taps(width)` returning the tap mask for widths 3..32 (maximal-length XNOR taps);
  - FSM state enum `sel_state_e` {IDLE, PROBE, GRANT}.
- Sub-module `lfsr_core` (W, `Seed`): holds the state register, `en_i`, `load_i`/`load_val_i` and the optional lock-up recovery, and exposes `state_o`. `lfsr_way_sel` instantiates it once.
- Elaboration checks reject out-of-range `LfsrWidth` and `NumWays`.

## Test plan
All scenarios use `LfsrWidth`=8, `NumWays`=8, `Seed`=0 unless stated otherwise.
1. **Sequence:** three requests with `avail_i`=0xFF.
   - Grants of ways 0, 1, 3 (LFSR 0x00 → 0x01 → 0x03).
   - Each grant arrives at +2; `way_oh_o` = 0x01, 0x02, 0x08.
2. **Probe:** load seed 0x05, then request with `avail_i`=0x81.
   - Candidate 5 fails, probe 6 fails, probe 7 hits.
   - `gnt_o` at +4 with `way_bin_o`=7.
3. **None available:** request with `avail_i`=0.
   - `gnt_o` at +2 with `none_o`=1 and `way_oh_o`=0.
   - LFSR is still 0x00 afterwards.
4. **Abort:** seed 0x05 and `avail_i`=0x01; drop `req_i` during the first PROBE cycle.
   - No `gnt_o`; FSM returns to IDLE; LFSR stays 0x05.
5. **Non-power-of-two:** `NumWays`=6, seed 0x07, `avail_i`=0x3F.
   - Grant of way 1 (7−6); `way_oh_o`=0x02.
6. **Lock-up:** load 0xFF.
   - With the macro: LFSR reads 0x00 one cycle later.
   - Without the macro: it remains 0xFF and successive grants all choose way 7.

Source files
------------

// File: rtl/lfsr_way_sel_pkg.sv
// Shared types and LFSR tap table for the pseudo-random way selector.
// Tap masks are maximal-length XNOR taps, bit i set means tap position i+1.
package lfsr_way_sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        GRANT = 2'd2
    } sel_state_e;

    // Tap positions are 1-based, as listed in the usual LFSR tables.
    function automatic logic [31:0] tap_bit(input int unsigned pos);
        return 32'd1 << (pos - 1);
    endfunction

    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] taps;
        taps = '0;
        case (width)
            3:  taps = tap_bit(3)  | tap_bit(2);
            4:  taps = tap_bit(4)  | tap_bit(3);
            5:  taps = tap_bit(5)  | tap_bit(3);
            6:  taps = tap_bit(6)  | tap_bit(5);
            7:  taps = tap_bit(7)  | tap_bit(6);
            8:  taps = tap_bit(8)  | tap_bit(6)  | tap_bit(5) | tap_bit(4);
            9:  taps = tap_bit(9)  | tap_bit(5);
            10: taps = tap_bit(10) | tap_bit(7);
            11: taps = tap_bit(11) | tap_bit(9);
            12: taps = tap_bit(12) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
            13: taps = tap_bit(13) | tap_bit(4)  | tap_bit(3) | tap_bit(1);
            14: taps = tap_bit(14) | tap_bit(5)  | tap_bit(3) | tap_bit(1);
            15: taps = tap_bit(15) | tap_bit(14);
            16: taps = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
            17: taps = tap_bit(17) | tap_bit(14);
            18: taps = tap_bit(18) | tap_bit(11);
            19: taps = tap_bit(19) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
            20: taps = tap_bit(20) | tap_bit(17);
            21: taps = tap_bit(21) | tap_bit(19);
            22: taps = tap_bit(22) | tap_bit(21);
            23: taps = tap_bit(23) | tap_bit(18);
            24: taps = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
            25: taps = tap_bit(25) | tap_bit(22);
            26: taps = tap_bit(26) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
            27: taps = tap_bit(27) | tap_bit(5)  | tap_bit(2) | tap_bit(1);
            28: taps = tap_bit(28) | tap_bit(25);
            29: taps = tap_bit(29) | tap_bit(27);
            30: taps = tap_bit(30) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
            31: taps = tap_bit(31) | tap_bit(28);
            32: taps = tap_bit(32) | tap_bit(22) | tap_bit(2) | tap_bit(1);
            default: taps = '0;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_way_sel_core.sv
// Fibonacci XNOR LFSR state register with load and step enable.
// Lock-up recovery from the all-ones state is built when LFSR_WAY_SEL_LOCKUP_RECOVERY_EN is defined.
module lfsr_core
    import lfsr_way_sel_pkg::*;
#(
    parameter int unsigned      W    = 16,
    parameter logic [W-1:0]     Seed = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] state_o
);

    localparam logic [31:0]  TapsFull = lfsr_taps(W);
    localparam logic [W-1:0] Taps     = TapsFull[W-1:0];

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Priority, lowest to highest: hold, step, load, lock-up recovery.
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = {q_q[W-2:0], ~(^(q_q & Taps))};
        end
        if (load_i) begin
            q_d = load_val_i;
        end
`ifdef LFSR_WAY_SEL_LOCKUP_RECOVERY_EN
        if (q_q == '1) begin
            q_d = Seed;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= Seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign state_o = q_q;

endmodule

// File: rtl/lfsr_way_sel.sv
// Pseudo-random victim way selector: LFSR candidate, sequential probing past unavailable ways, req/gnt.
// Optional LFSR lock-up recovery is enabled with LFSR_WAY_SEL_LOCKUP_RECOVERY_EN.
module lfsr_way_sel
    import lfsr_way_sel_pkg::*;
#(
    parameter int unsigned          LfsrWidth = 16,
    parameter int unsigned          NumWays   = 8,
    parameter logic [LfsrWidth-1:0] Seed      = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       seed_load_i,
    input  logic [LfsrWidth-1:0]       seed_i,
    input  logic                       req_i,
    input  logic [NumWays-1:0]         avail_i,
    output logic                       gnt_o,
    output logic [NumWays-1:0]         way_oh_o,
    output logic [$clog2(NumWays)-1:0] way_bin_o,
    output logic                       none_o,
    output sel_state_e                 dbg_state_o,
    output logic [LfsrWidth-1:0]       dbg_lfsr_o
);

    // Handshake: req_i is held high until gnt_o; gnt_o is a one-cycle pulse and
    // way_oh_o/way_bin_o/none_o are meaningful only while gnt_o is high.

    localparam int unsigned      IdxW     = $clog2(NumWays);
    localparam logic [IdxW:0]    NumWaysW = (IdxW + 1)'(NumWays);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumWays - 1);

    if (LfsrWidth < 3 || LfsrWidth > 32) begin : g_bad_width
        $error("lfsr_way_sel: LfsrWidth must be in 3..32");
    end
    if (NumWays < 2 || 64'(NumWays) > (64'd1 << LfsrWidth)) begin : g_bad_ways
        $error("lfsr_way_sel: NumWays must be in 2..2**LfsrWidth");
    end

    function automatic logic [IdxW-1:0] inc_wrap(input logic [IdxW-1:0] i);
        return (i == LastIdx) ? '0 : i + IdxW'(1);
    endfunction

    function automatic logic [NumWays-1:0] to_onehot(input logic [IdxW-1:0] i);
        logic [NumWays-1:0] one;
        one = '0;
        one[0] = 1'b1;
        return one << i;
    endfunction

    sel_state_e           state_q, state_d;
    logic [IdxW-1:0]      cand_q, cand_d;
    logic [IdxW-1:0]      way_bin_q, way_bin_d;
    logic [NumWays-1:0]   way_oh_q, way_oh_d;
    logic                 none_q, none_d;
    logic [LfsrWidth-1:0] lfsr_q;
    logic [IdxW-1:0]      idx_raw;
    logic [IdxW-1:0]      idx;
    logic                 lfsr_step;

    lfsr_core #(
        .W    (LfsrWidth),
        .Seed (Seed)
    ) u_lfsr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (lfsr_step),
        .load_i     (seed_load_i),
        .load_val_i (seed_i),
        .state_o    (lfsr_q)
    );

    // The raw index is below 2*NumWays, so one subtraction folds it into range.
    assign idx_raw = lfsr_q[IdxW-1:0];
    always_comb begin
        idx = idx_raw;
        if ({1'b0, idx_raw} >= NumWaysW) begin
            idx = idx_raw - NumWaysW[IdxW-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        way_bin_d = way_bin_q;
        way_oh_d  = way_oh_q;
        none_d    = none_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (avail_i == '0) begin
                        none_d    = 1'b1;
                        way_bin_d = '0;
                        way_oh_d  = '0;
                        state_d   = GRANT;
                    end else if (avail_i[idx]) begin
                        none_d    = 1'b0;
                        way_bin_d = idx;
                        way_oh_d  = to_onehot(idx);
                        state_d   = GRANT;
                    end else begin
                        cand_d  = inc_wrap(idx);
                        state_d = PROBE;
                    end
                end
            end
            PROBE: begin
                if (!req_i) begin
                    state_d = IDLE;
                end else if (avail_i == '0) begin
                    none_d    = 1'b1;
                    way_bin_d = '0;
                    way_oh_d  = '0;
                    state_d   = GRANT;
                end else if (avail_i[cand_q]) begin
                    none_d    = 1'b0;
                    way_bin_d = cand_q;
                    way_oh_d  = to_onehot(cand_q);
                    state_d   = GRANT;
                end else begin
                    cand_d = inc_wrap(cand_q);
                end
            end
            GRANT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            way_bin_q <= '0;
            way_oh_q  <= '0;
            none_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            way_bin_q <= way_bin_d;
            way_oh_q  <= way_oh_d;
            none_q    <= none_d;
        end
    end

    // A "none" grant consumes no randomness, so the LFSR holds.
    assign lfsr_step = (state_q == GRANT) && !none_q;

    assign gnt_o       = (state_q == GRANT);
    assign way_oh_o    = way_oh_q;
    assign way_bin_o   = way_bin_q;
    assign none_o      = none_q;
    assign dbg_state_o = state_q;
    assign dbg_lfsr_o  = lfsr_q;

endmodule
